// File: rtl/dna_pkg.sv
// Shared DNA-word definitions for the deletion candidate sequencer.
//   dna_digit_t    : one 2-bit base (A/C/G/T)
//   DIG_*          : base encodings
//   seq_state_t    : sequencer FSM state
//   IDXW           : width of digit-index fields
package dna_pkg;

    localparam int IDXW = 7;

    typedef logic [1:0] dna_digit_t;

    localparam dna_digit_t DIG_A = 2'd0;
    localparam dna_digit_t DIG_C = 2'd1;
    localparam dna_digit_t DIG_G = 2'd2;
    localparam dna_digit_t DIG_T = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/candidate_insert.sv
// Combinational single-digit insertion.
// Builds an N-digit word from an (N-1)-digit word by placing dig_i at
// left-to-right position pos_i and shifting the remaining digits right.
//   word_i : N-1 digits, ltr digit q at [2*(N-2-q) +: 2]
//   pos_i  : insertion position, 0..N-1
//   dig_i  : inserted digit
//   word_o : N digits, ltr digit p at [2*(N-1-p) +: 2]
module candidate_insert
    import dna_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [2*(N-1)-1:0] word_i,
    input  logic [IDXW-1:0]    pos_i,
    input  dna_digit_t         dig_i,
    output logic [2*N-1:0]     word_o
);

    // Each output position picks one of three sources: the input digit at
    // the same index (left of the insertion), the new digit, or the input
    // digit one to the left (right of the insertion). The edge positions
    // only have two legal sources, so they are split out to keep every
    // part-select in range.
    for (genvar j = 0; j < N; j++) begin : g_pos
        if (j == 0) begin : g_first
            assign word_o[2*(N-1) +: 2] = (pos_i == '0) ? dig_i : word_i[2*(N-2) +: 2];
        end else if (j == N-1) begin : g_end
            assign word_o[1:0] = (pos_i == IDXW'(N-1)) ? dig_i : word_i[1:0];
        end else begin : g_mid
            assign word_o[2*(N-1-j) +: 2] =
                (pos_i >  IDXW'(j)) ? word_i[2*(N-2-j) +: 2] :
                (pos_i == IDXW'(j)) ? dig_i :
                                      word_i[2*(N-1-j) +: 2];
        end
    end

endmodule

// File: rtl/deletion_candidate_sequencer.sv
// Enumerates every distinct N-digit codeword obtainable by inserting one
// digit into a received (N-1)-digit word, one candidate per handshake.
// Insertions that would duplicate an earlier candidate (inserting d right
// after an existing d) are skipped combinationally, so 3N+1 candidates are
// streamed per word with no bubbles.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_valid/s_ready/s_word   : input word handshake (s_ready high in IDLE)
//   m_valid/m_ready          : candidate handshake
//   m_word/m_index/m_digit   : candidate word, insert position, inserted digit
//   m_last                   : final candidate of the word
//   abort                    : drop the current enumeration (no done pulse)
//   busy                     : enumeration in progress
//   done                     : one-cycle pulse after the last accept
//   cand_count               : candidates accepted for the current/last word
module deletion_candidate_sequencer
    import dna_pkg::*;
#(
    parameter int N = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [2*(N-1)-1:0]  s_word,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*N-1:0]      m_word,
    output logic [IDXW-1:0]     m_index,
    output logic [1:0]          m_digit,
    output logic                m_last,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [7:0]          cand_count
);

    seq_state_t          state_q;
    logic [2*(N-1)-1:0]  word_q;
    logic [IDXW-1:0]     p_q;
    dna_digit_t          d_q;
    logic                m_valid_q;
    logic                last_q;
    logic                done_q;
    logic [2*N-1:0]      m_word_q;
    logic [7:0]          cnt_q;

    function automatic dna_digit_t in_digit(input logic [2*(N-1)-1:0] w,
                                            input logic [IDXW-1:0]    q);
        int sh;
        sh = 2 * (N - 2 - int'(q));
        if (sh < 0) sh = 0;
        return w[sh +: 2];
    endfunction

    // Inserting d right after an existing d gives the same word as
    // inserting it one position earlier; only the leftmost of a run counts.
    function automatic logic is_skip(input logic [2*(N-1)-1:0] w,
                                     input logic [IDXW-1:0]    p,
                                     input dna_digit_t         d);
        return (p != '0) && (in_digit(w, p - IDXW'(1)) == d);
    endfunction

    // At the final position d=3 is skipped when the last input digit is T,
    // which moves the end of the enumeration to d=2.
    function automatic logic is_last(input logic [2*(N-1)-1:0] w,
                                     input logic [IDXW-1:0]    p,
                                     input dna_digit_t         d);
        return (p == IDXW'(N-1)) &&
               ((d == DIG_T) || ((d == DIG_G) && (in_digit(w, IDXW'(N-2)) == DIG_T)));
    endfunction

    // Next (p,d) after the current one. At most two consecutive pairs can be
    // skipped (one per position), so three unrolled steps always suffice.
    logic [IDXW-1:0] p_d;
    dna_digit_t      d_d;
    logic            hit_d;
    logic            last_d;

    always_comb begin
        p_d   = p_q;
        d_d   = d_q;
        hit_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!hit_d) begin
                if (d_d == DIG_T) begin
                    d_d = DIG_A;
                    p_d = p_d + IDXW'(1);
                end else begin
                    d_d = d_d + 2'd1;
                end
                hit_d = !is_skip(word_q, p_d, d_d);
            end
        end
        last_d = is_last(word_q, p_d, d_d);
    end

    // In IDLE the word has not been captured yet, so the first candidate
    // (0, A) is built straight from s_word.
    logic [2*(N-1)-1:0] ins_w;
    logic [IDXW-1:0]    ins_p;
    dna_digit_t         ins_d;
    logic [2*N-1:0]     ins_word;

    assign ins_w = (state_q == IDLE) ? s_word : word_q;
    assign ins_p = (state_q == IDLE) ? '0     : p_d;
    assign ins_d = (state_q == IDLE) ? DIG_A  : d_d;

    candidate_insert #(.N(N)) u_insert (
        .word_i (ins_w),
        .pos_i  (ins_p),
        .dig_i  (ins_d),
        .word_o (ins_word)
    );

    logic accept;
    assign accept = m_valid_q && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            p_q       <= '0;
            d_q       <= DIG_A;
            m_valid_q <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            m_word_q  <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        state_q   <= RUN;
                        word_q    <= s_word;
                        cnt_q     <= '0;
                        p_q       <= '0;
                        d_q       <= DIG_A;
                        m_word_q  <= ins_word;
                        last_q    <= 1'b0;
                        m_valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    // A beat accepted together with abort still counts.
                    if (accept && (cnt_q != 8'hFF)) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    if (abort) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                    end else if (accept) begin
                        if (last_q) begin
                            state_q   <= IDLE;
                            m_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            p_q      <= p_d;
                            d_q      <= d_d;
                            m_word_q <= ins_word;
                            last_q   <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready    = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign m_valid    = m_valid_q;
    assign m_word     = m_word_q;
    assign m_index    = p_q;
    assign m_digit    = d_q;
    assign m_last     = last_q;
    assign done       = done_q;
    assign cand_count = cnt_q;

endmodule

// File: tb/tb_deletion_candidate_sequencer.sv
module tb_deletion_candidate_sequencer;

    typedef struct packed {
        logic [11:0] word;
        logic [6:0]  idx;
        logic [1:0]  dig;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=4 instance
    logic       s_valid4, s_ready4, m_valid4, m_ready4, m_last4, abort4, busy4, done4;
    logic [5:0] s_word4;
    logic [7:0] m_word4, cnt4;
    logic [6:0] m_index4;
    logic [1:0] m_digit4;

    // N=6 instance
    logic        s_valid6, s_ready6, m_valid6, m_ready6, m_last6, abort6, busy6, done6;
    logic [9:0]  s_word6;
    logic [11:0] m_word6;
    logic [7:0]  cnt6;
    logic [6:0]  m_index6;
    logic [1:0]  m_digit6;

    deletion_candidate_sequencer #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4), .s_word(s_word4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_word(m_word4), .m_index(m_index4),
        .m_digit(m_digit4), .m_last(m_last4), .abort(abort4), .busy(busy4),
        .done(done4), .cand_count(cnt4)
    );

    deletion_candidate_sequencer #(.N(6)) dut6 (
        .clk(clk), .rst(rst), .s_valid(s_valid6), .s_ready(s_ready6), .s_word(s_word6),
        .m_valid(m_valid6), .m_ready(m_ready6), .m_word(m_word6), .m_index(m_index6),
        .m_digit(m_digit6), .m_last(m_last6), .abort(abort6), .busy(busy6),
        .done(done6), .cand_count(cnt6)
    );

    exp_t q4[$];
    exp_t q6[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop on every accepted beat, and check that a
    // stalled beat is held unchanged.
    initial begin
        exp_t cur, prev, e;
        logic stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = '{word: {4'b0, m_word4}, idx: m_index4, dig: m_digit4, last: m_last4};
            if (!rst && stall) chk("hold4", 32'({m_valid4, cur}), 32'({1'b1, prev}));
            if (!rst && m_valid4 && m_ready4) begin
                if (q4.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra4 actual=%0h expected=none", cur);
                end else begin
                    e = q4.pop_front();
                    chk("cand4", 32'(cur), 32'(e));
                end
            end
            stall = !rst && m_valid4 && !m_ready4;
            prev  = cur;
        end
    end

    initial begin
        exp_t cur, e;
        forever begin
            @(negedge clk);
            cur = '{word: m_word6, idx: m_index6, dig: m_digit6, last: m_last6};
            if (!rst && m_valid6 && m_ready6) begin
                if (q6.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra6 actual=%0h expected=none", cur);
                end else begin
                    e = q6.pop_front();
                    chk("cand6", 32'(cur), 32'(e));
                end
            end
        end
    end

    // Reference for N=4: try every (p,d) in order, keep only words not seen
    // before; the final kept word is the last one.
    task automatic model4(input logic [5:0] w, input int limit);
        exp_t       lst[$];
        logic [1:0] ind[3];
        logic [1:0] dg;
        logic [7:0] c;
        bit         dup;
        for (int q = 0; q < 3; q++) ind[q] = w[2*(2-q) +: 2];
        for (int p = 0; p < 4; p++) begin
            for (int d = 0; d < 4; d++) begin
                for (int j = 0; j < 4; j++) begin
                    if (j < p)       dg = ind[j];
                    else if (j == p) dg = 2'(d);
                    else             dg = ind[j-1];
                    c[2*(3-j) +: 2] = dg;
                end
                dup = 1'b0;
                foreach (lst[i]) if (lst[i].word == {4'b0, c}) dup = 1'b1;
                if (!dup) lst.push_back('{word: {4'b0, c}, idx: 7'(p), dig: 2'(d), last: 1'b0});
            end
        end
        lst[lst.size()-1].last = 1'b1;
        for (int i = 0; i < limit && i < lst.size(); i++) q4.push_back(lst[i]);
    endtask

    task automatic start4(input logic [5:0] w);
        s_word4  = w;
        s_valid4 = 1'b1;
        @(posedge clk); #1;
        s_valid4 = 1'b0;
    endtask

    task automatic wait_done4(input bit toggle, output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            if (toggle) m_ready4 = ~m_ready4;
            @(posedge clk); #1;
            cyc++;
            if (done4) break;
        end
        if (!done4) begin
            checks++; failures++;
            $display("FAIL done4_timeout actual=0 expected=1");
        end
        m_ready4 = 1'b1;
    endtask

    logic [7:0] t1w[13] = '{8'h05, 8'h45, 8'h85, 8'hC5, 8'h15, 8'h25, 8'h35,
                            8'h11, 8'h19, 8'h1D, 8'h14, 8'h16, 8'h17};
    int t1p[13] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    int t1d[13] = '{0, 1, 2, 3, 1, 2, 3, 0, 2, 3, 0, 2, 3};

    initial begin
        int         cyc;
        logic [11:0] w6;

        rst = 1'b1;
        s_valid4 = 1'b0; s_word4 = '0; m_ready4 = 1'b1; abort4 = 1'b0;
        s_valid6 = 1'b0; s_word6 = '0; m_ready6 = 1'b1; abort6 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid4), 0);
        chk("rst_s_ready", 32'(s_ready4), 1);
        chk("rst_busy",    32'(busy4), 0);
        chk("rst_done",    32'(done4), 0);
        chk("rst_count",   32'(cnt4), 0);
        chk("rst_m_word",  32'({m_word4, m_index4, m_digit4, m_last4}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: ACC, continuous ready, fixed expected table
        for (int i = 0; i < 13; i++)
            q4.push_back('{word: {4'b0, t1w[i]}, idx: 7'(t1p[i]), dig: 2'(t1d[i]), last: (i == 12)});
        start4(6'b00_01_01);
        chk("t1_busy", 32'(busy4), 1);
        wait_done4(1'b0, cyc);
        chk("t1_cycles", 32'(cyc), 13);
        chk("t1_count",  32'(cnt4), 13);
        chk("t1_idle",   32'({m_valid4, s_ready4}), 32'b01);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(done4), 0);
        chk("t1_count_hold", 32'(cnt4), 13);

        // 2: same word, ready toggling
        for (int i = 0; i < 13; i++)
            q4.push_back('{word: {4'b0, t1w[i]}, idx: 7'(t1p[i]), dig: 2'(t1d[i]), last: (i == 12)});
        m_ready4 = 1'b0;
        start4(6'b00_01_01);
        wait_done4(1'b1, cyc);
        chk("t2_count", 32'(cnt4), 13);
        chk("t2_q_empty", 32'(q4.size()), 0);

        // 3: N=6, all T
        for (int p = 0; p < 6; p++) begin
            for (int d = 0; d < 4; d++) begin
                if (p > 0 && d == 3) continue;
                w6 = 12'hFFF;
                w6[2*(5-p) +: 2] = 2'(d);
                q6.push_back('{word: w6, idx: 7'(p), dig: 2'(d), last: (p == 5 && d == 2)});
            end
        end
        s_word6 = 10'h3FF; s_valid6 = 1'b1;
        @(posedge clk); #1;
        s_valid6 = 1'b0;
        cyc = 0;
        while (cyc < 200 && !done6) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t3_cycles", 32'(cyc), 19);
        chk("t3_count",  32'(cnt6), 19);

        // 4: abort after 5 accepts, 6th beat accepted with abort
        model4(6'b11_10_00, 6);
        start4(6'b11_10_00);
        repeat (5) @(posedge clk);
        #1;
        abort4 = 1'b1;
        @(posedge clk); #1;
        abort4 = 1'b0;
        chk("t4_count",   32'(cnt4), 6);
        chk("t4_state",   32'({m_valid4, s_ready4, busy4, done4}), 32'b0100);
        @(posedge clk); #1;
        chk("t4_no_done", 32'(done4), 0);
        model4(6'b11_10_00, 100);
        start4(6'b11_10_00);
        wait_done4(1'b0, cyc);
        chk("t4_restart_count", 32'(cnt4), 13);

        // 5: reset mid-run
        model4(6'b10_01_11, 3);
        start4(6'b10_01_11);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_outputs", 32'({m_valid4, m_word4, m_index4, m_digit4, m_last4, done4, busy4}), 0);
        chk("t5_count",   32'(cnt4), 0);
        chk("t5_s_ready", 32'(s_ready4), 1);
        rst = 1'b0;
        model4(6'b10_10_01, 100);
        start4(6'b10_10_01);
        wait_done4(1'b0, cyc);
        chk("t5_restart_count", 32'(cnt4), 13);
        @(posedge clk); #1;

        // 6: back-to-back with s_valid held
        model4(6'b00_00_00, 100);
        model4(6'b01_10_11, 100);
        s_word4 = 6'b00_00_00; s_valid4 = 1'b1;
        @(posedge clk); #1;
        s_word4 = 6'b01_10_11;
        wait_done4(1'b0, cyc);
        chk("t6_first_cycles", 32'(cyc), 13);
        chk("t6_ready_at_done", 32'(s_ready4), 1);
        @(posedge clk); #1;
        s_valid4 = 1'b0;
        chk("t6_second_start", 32'({busy4, m_valid4, done4}), 32'b110);
        chk("t6_count_clear",  32'(cnt4), 0);
        wait_done4(1'b0, cyc);
        chk("t6_second_count", 32'(cnt4), 13);

        @(posedge clk); #1;
        chk("q4_empty", 32'(q4.size()), 0);
        chk("q6_empty", 32'(q6.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
